// File: rtl/al_is_buf_if.sv
// al_is_buf_if -- bundle handshake between allocation, the AL->IS buffer,
// the issue stage and the ROB flush bus.
//   slave  : buffer side (takes bundles/flush/issue back-pressure, drives
//            full, head bundle, head loop flag and occupancy)
//   master : environment side (allocation + issue + ROB)
interface al_is_buf_if #(
  parameter int INST_WIDTH = 56,
  parameter int INST_PORT  = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int BRN_WIDTH  = 7
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [INST_PORT*INST_WIDTH-1:0] inst_frm_al;
  logic                            lop_sta_frm_al;
  logic                            ful_to_al;
  logic [INST_PORT*INST_WIDTH-1:0] inst_to_is;
  logic                            lop_sta_to_is;
  logic                            ful_frm_is;
  logic [BRN_WIDTH-1:0]            fls_frm_rob;
  logic [CNT_W-1:0]                cnt_out;

  modport slave (
    input  inst_frm_al, lop_sta_frm_al, ful_frm_is, fls_frm_rob,
    output ful_to_al, inst_to_is, lop_sta_to_is, cnt_out
  );

  modport master (
    output inst_frm_al, lop_sta_frm_al, ful_frm_is, fls_frm_rob,
    input  ful_to_al, inst_to_is, lop_sta_to_is, cnt_out
  );
endinterface

// File: rtl/al_is_buf.sv
// al_is_buf -- small bundle FIFO between allocation and issue.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears pointers and all entries
//   bus   : al_is_buf_if.slave
//             inst_frm_al / lop_sta_frm_al : bundle and loop flag to push
//             ful_to_al                    : buffer full, allocation holds
//             inst_to_is / lop_sta_to_is   : head bundle (zero when not visible)
//             ful_frm_is                   : issue queue full, head not consumed
//             fls_frm_rob                  : MSB is flush valid
//             cnt_out                      : occupancy
module al_is_buf #(
  parameter int INST_WIDTH = 56,
  parameter int INST_PORT  = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int BRN_WIDTH  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  al_is_buf_if.slave  bus
);

  localparam int BUN_W = INST_PORT * INST_WIDTH;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUN_W-1:0]     ent_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] lop_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     cnt_q;

  logic bun_vld;
  logic flush;
  logic full;
  logic push;
  logic pop;

  // Only the flush valid bit matters here; the branch index is for other units.
  logic unused_fls_idx;
  assign unused_fls_idx = ^bus.fls_frm_rob[BRN_WIDTH-2:0];

  always_comb begin
    bun_vld = 1'b0;
    for (int i = 0; i < INST_PORT; i++) begin
      bun_vld = bun_vld | bus.inst_frm_al[i*INST_WIDTH + INST_WIDTH - 1];
    end
  end

  assign flush = bus.fls_frm_rob[BRN_WIDTH-1];
  // Full comes from registered occupancy, so a pop in a full cycle cannot
  // open a slot for a push until the following cycle.
  assign full  = (cnt_q == CNT_W'(BUF_DEPTH));
  assign push  = bun_vld & ~full & ~flush;
  assign pop   = (cnt_q != '0) & ~bus.ful_frm_is & ~flush;

  assign bus.ful_to_al     = full;
  assign bus.cnt_out       = cnt_q;
  assign bus.inst_to_is    = pop ? ent_q[head_q] : '0;
  assign bus.lop_sta_to_is = pop ? lop_q[head_q] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Flush only rewinds pointers; stale entry contents are harmless because
  // they are unreachable until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      lop_q <= '0;
    end else if (push) begin
      ent_q[tail_q] <= bus.inst_frm_al;
      lop_q[tail_q] <= bus.lop_sta_frm_al;
    end
  end

endmodule

// File: tb/tb_al_is_buf.sv
module tb_al_is_buf;
  localparam int IW  = 56;
  localparam int IP  = 4;
  localparam int BD  = 4;
  localparam int BRW = 7;
  localparam int BW  = IW * IP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  al_is_buf_if #(.INST_WIDTH(IW), .INST_PORT(IP), .BUF_DEPTH(BD), .BRN_WIDTH(BRW)) bus ();

  al_is_buf #(.INST_WIDTH(IW), .INST_PORT(IP), .BUF_DEPTH(BD), .BRN_WIDTH(BRW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    string           name;
    logic [BW-1:0]   inst;
    logic            lop;
    logic            ful_is;
    logic [BRW-1:0]  fls;
    logic            e_ful;
    logic [BW-1:0]   e_inst;
    logic            e_lop;
    logic [2:0]      e_cnt;
  } vec_t;

  typedef struct {
    logic [BW-1:0] inst;
    logic          lop;
  } ent_t;

  vec_t vt[$];
  ent_t mq[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic e_ful, input logic [BW-1:0] e_inst,
                          input logic e_lop, input logic [2:0] e_cnt);
    chk({name, ".ful_to_al"},     BW'(bus.ful_to_al),     BW'(e_ful));
    chk({name, ".inst_to_is"},    bus.inst_to_is,         e_inst);
    chk({name, ".lop_sta_to_is"}, BW'(bus.lop_sta_to_is), BW'(e_lop));
    chk({name, ".cnt_out"},       BW'(bus.cnt_out),       BW'(e_cnt));
  endtask

  // Slot i carries n^(i<<8) in its low bits; vm selects which slot valid bits are set.
  function automatic logic [BW-1:0] mk(input int n, input logic [IP-1:0] vm);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < IP; i++) begin
      r[i*IW +: 32] = 32'(n ^ (i << 8));
      r[i*IW + IW - 1] = vm[i];
    end
    return r;
  endfunction

  function automatic vec_t v(input string name, input logic [BW-1:0] inst, input logic lop,
                             input logic ful_is, input logic [BRW-1:0] fls, input logic e_ful,
                             input logic [BW-1:0] e_inst, input logic e_lop, input logic [2:0] e_cnt);
    vec_t r;
    r.name = name; r.inst = inst; r.lop = lop; r.ful_is = ful_is; r.fls = fls;
    r.e_ful = e_ful; r.e_inst = e_inst; r.e_lop = e_lop; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(input logic [BW-1:0] inst, input logic lop, input logic ful_is,
                       input logic [BRW-1:0] fls);
    bus.inst_frm_al    = inst;
    bus.lop_sta_frm_al = lop;
    bus.ful_frm_is     = ful_is;
    bus.fls_frm_rob    = fls;
  endtask

  logic [BW-1:0] a, b1, b2, b3, b4, b5, c1, c2, c3, c4, c5, d1, d2, d3, d4, f1, f2, g1, inv, z;

  initial begin
    z   = '0;
    a   = mk(32'hA, 4'b0001);
    b1  = mk(32'hB1, 4'b0001);
    b2  = mk(32'hB2, 4'b0010);
    b3  = mk(32'hB3, 4'b0100);
    b4  = mk(32'hB4, 4'b1000);
    b5  = mk(32'hB5, 4'b1111);
    c1  = mk(32'hC1, 4'b0011);
    c2  = mk(32'hC2, 4'b0001);
    c3  = mk(32'hC3, 4'b1000);
    c4  = mk(32'hC4, 4'b0101);
    c5  = mk(32'hC5, 4'b0001);
    d1  = mk(32'hD1, 4'b0001);
    d2  = mk(32'hD2, 4'b0001);
    d3  = mk(32'hD3, 4'b0001);
    d4  = mk(32'hD4, 4'b0001);
    f1  = mk(32'hF1, 4'b0001);
    f2  = mk(32'hF2, 4'b0001);
    g1  = mk(32'h61, 4'b0010);
    inv = mk(32'hFF, 4'b0000);

    //          name        inst lop fis fls    e_ful e_inst lop cnt
    vt.push_back(v("idle0",   z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_a",  a,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("a_out",   z,  0, 0, 7'h3F, 0, a,  0, 1));
    vt.push_back(v("a_gone",  z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_b1", b1, 1, 1, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_b2", b2, 0, 1, 7'h00, 0, z,  0, 1));
    vt.push_back(v("push_b3", b3, 1, 1, 7'h00, 0, z,  0, 2));
    vt.push_back(v("push_b4", b4, 0, 1, 7'h00, 0, z,  0, 3));
    vt.push_back(v("push_b5", b5, 1, 1, 7'h00, 1, z,  0, 4));
    vt.push_back(v("b1_out",  z,  0, 0, 7'h00, 1, b1, 1, 4));
    vt.push_back(v("b2_out",  z,  0, 0, 7'h00, 0, b2, 0, 3));
    vt.push_back(v("b3_out",  z,  0, 0, 7'h00, 0, b3, 1, 2));
    vt.push_back(v("b4_out",  z,  0, 0, 7'h00, 0, b4, 0, 1));
    vt.push_back(v("b_empty", z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("invalid", inv,1, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("inv_gone",z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_c1", c1, 0, 1, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_c2", c2, 1, 1, 7'h00, 0, z,  0, 1));
    vt.push_back(v("push_c3", c3, 0, 1, 7'h00, 0, z,  0, 2));
    vt.push_back(v("push_c4", c4, 1, 1, 7'h00, 0, z,  0, 3));
    vt.push_back(v("full_pop",c5, 1, 0, 7'h00, 1, c1, 0, 4));
    vt.push_back(v("c5_held", c5, 1, 1, 7'h00, 0, z,  0, 3));
    vt.push_back(v("c2_out",  z,  0, 0, 7'h00, 1, c2, 1, 4));
    vt.push_back(v("c3_out",  z,  0, 0, 7'h00, 0, c3, 0, 3));
    vt.push_back(v("c4_out",  z,  0, 0, 7'h00, 0, c4, 1, 2));
    vt.push_back(v("c5_out",  z,  0, 0, 7'h00, 0, c5, 1, 1));
    vt.push_back(v("c_empty", z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_d1", d1, 0, 1, 7'h00, 0, z,  0, 0));
    vt.push_back(v("push_d2", d2, 0, 1, 7'h00, 0, z,  0, 1));
    vt.push_back(v("push_d3", d3, 0, 1, 7'h00, 0, z,  0, 2));
    vt.push_back(v("flush_pu",d4, 1, 0, 7'h40, 0, z,  0, 3));
    vt.push_back(v("flushed", z,  0, 0, 7'h00, 0, z,  0, 0));
    vt.push_back(v("fls_empt",z,  0, 0, 7'h7F, 0, z,  0, 0));
    vt.push_back(v("post_fls",z,  0, 0, 7'h00, 0, z,  0, 0));

    drive(z, 1'b0, 1'b0, '0);
    #1;
    chk_outs("in_reset", 1'b0, z, 1'b0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].inst, vt[i].lop, vt[i].ful_is, vt[i].fls);
      #1;
      chk_outs(vt[i].name, vt[i].e_ful, vt[i].e_inst, vt[i].e_lop, vt[i].e_cnt);
    end

    // Wrap-around: a push every cycle, issue stalls on some cycles, queue model.
    for (int k = 0; k < 12; k++) begin
      ent_t e;
      logic fis;
      logic [BW-1:0] exp_inst;
      logic exp_lop;
      bit was_full;
      e.inst = mk(32'h100 + k, 4'(1 << (k % 4)));
      e.lop  = k[0];
      fis    = (k % 4 == 1);
      @(negedge clk);
      drive(e.inst, e.lop, fis, '0);
      #1;
      exp_inst = (mq.size() > 0 && !fis) ? mq[0].inst : z;
      exp_lop  = (mq.size() > 0 && !fis) ? mq[0].lop  : 1'b0;
      was_full = (mq.size() == BD);
      chk_outs($sformatf("wrap%0d", k), was_full, exp_inst, exp_lop, 3'(mq.size()));
      if (mq.size() > 0 && !fis) void'(mq.pop_front());
      if (!was_full) mq.push_back(e);
    end
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      @(negedge clk);
      drive(z, 1'b0, 1'b0, '0);
      #1;
      chk_outs($sformatf("drain%0d", k), mq.size() == BD, mq[0].inst, mq[0].lop, 3'(mq.size()));
      void'(mq.pop_front());
    end
    @(negedge clk);
    drive(z, 1'b0, 1'b0, '0);
    #1;
    chk_outs("drained", 1'b0, z, 1'b0, 3'd0);

    // Asynchronous reset between edges with two entries held.
    @(negedge clk);
    drive(f1, 1'b1, 1'b1, '0);
    @(negedge clk);
    drive(f2, 1'b0, 1'b1, '0);
    @(negedge clk);
    drive(z, 1'b0, 1'b0, '0);
    #1;
    chk_outs("pre_rst", 1'b0, f1, 1'b1, 3'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, z, 1'b0, 3'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(g1, 1'b1, 1'b0, '0);
    #1;
    chk_outs("post_rst_push", 1'b0, z, 1'b0, 3'd0);
    @(negedge clk);
    drive(z, 1'b0, 1'b0, '0);
    #1;
    chk_outs("post_rst_out", 1'b0, g1, 1'b1, 3'd1);
    @(negedge clk);
    #1;
    chk_outs("post_rst_empty", 1'b0, z, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
